// File: rtl/cpu_pkg.sv
// Shared definitions for the 5-stage MIPS core: the decoded control bundle,
// ALU operation classes and the canonical bubble / $zero encodings.
package cpu_pkg;

    // Decoded control bits carried down the pipeline alongside the operands.
    typedef struct packed {
        logic       regwrite;
        logic       memread;
        logic       memwrite;
        logic       memtoreg;
        logic       alusrc;
        logic       regdst;
        logic [1:0] aluop;
    } ctrl_t;

    // ALU operation classes consumed by the ALU control in EX.
    localparam logic [1:0] ALUOP_ADD    = 2'b00;  // loads/stores: address add
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;  // beq: subtract for compare
    localparam logic [1:0] ALUOP_RTYPE  = 2'b10;  // decode funct field
    localparam logic [1:0] ALUOP_IMM    = 2'b11;  // immediate arithmetic/logic

    // A bubble is an instruction with every control bit cleared: it writes
    // nothing, reads no memory and cannot itself cause a hazard.
    localparam ctrl_t CTRL_BUBBLE = '0;

    // Architectural $zero register; never a real dependency.
    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_detection_unit.sv
// Load-use hazard detection. Purely combinational: looks at the load sitting
// in EX and the instruction in ID, and decides whether ID must wait a cycle.
// A taken-branch flush always wins, since the ID instruction is being
// discarded anyway and freezing the front end would lose the branch target.
module hazard_detection_unit
    import cpu_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic             idex_memread_i,
    input  logic [REG_W-1:0] idex_reg_rt_i,
    input  logic [REG_W-1:0] ifid_reg_rs_i,
    input  logic [REG_W-1:0] ifid_reg_rt_i,
    input  logic             flush_i,
    output logic             load_use_o,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             insert_bubble_o
);

    logic rt_is_zero;
    logic rt_matches;

    // Detect a consumer in ID of the value a load in EX has not produced yet,
    // then derive front-end enables and the bubble request.
    always_comb begin
        rt_is_zero      = (idex_reg_rt_i == REG_W'(REG_ZERO));
        rt_matches      = (idex_reg_rt_i == ifid_reg_rs_i) ||
                          (idex_reg_rt_i == ifid_reg_rt_i);
        load_use_o      = idex_memread_i && !rt_is_zero && rt_matches;

        // Freeze PC and IF/ID only for a genuine stall, never on a flush.
        pc_write_o      = !(load_use_o && !flush_i);
        ifid_write_o    = !(load_use_o && !flush_i);

        // Either condition replaces the ID instruction with a bubble.
        insert_bubble_o = flush_i || load_use_o;
    end

endmodule

// File: rtl/idex_stage.sv
// ID/EX pipeline register. Captures operands, register numbers and control
// from ID for use in EX one cycle later, substitutes a bubble on a load-use
// stall or branch flush, and counts load-use stall cycles (saturating).
//
// Handshake: this stage has no valid/ready pair. The front end advances
// whenever pc_write/IFID_write are 1; when they are 0 the IF/ID contents are
// held and presented again next cycle while a bubble enters EX.
module idex_stage
    import cpu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_W-1:0]  IFID_reg_rs,
    input  logic [REG_W-1:0]  IFID_reg_rt,
    input  logic [REG_W-1:0]  IFID_reg_rd,
    input  logic [DATA_W-1:0] reg_read_data_1,
    input  logic [DATA_W-1:0] reg_read_data_2,
    input  logic [DATA_W-1:0] sign_ext_imm,
    input  ctrl_t             id_ctrl,
    input  logic              flush,
    output logic [REG_W-1:0]  IDEX_reg_rs,
    output logic [REG_W-1:0]  IDEX_reg_rt,
    output logic [REG_W-1:0]  IDEX_reg_rd,
    output logic [DATA_W-1:0] IDEX_read_data_1,
    output logic [DATA_W-1:0] IDEX_read_data_2,
    output logic [DATA_W-1:0] IDEX_imm,
    output ctrl_t             IDEX_ctrl,
    output logic              pc_write,
    output logic              IFID_write,
    output logic [CNT_W-1:0]  stall_count
);

    // Pipeline register state.
    logic [REG_W-1:0]  rs_q, rs_d;
    logic [REG_W-1:0]  rt_q, rt_d;
    logic [REG_W-1:0]  rd_q, rd_d;
    logic [DATA_W-1:0] data1_q, data1_d;
    logic [DATA_W-1:0] data2_q, data2_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    ctrl_t             ctrl_q, ctrl_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic load_use_w;
    logic pc_write_w;
    logic ifid_write_w;
    logic insert_bubble_w;

    hazard_detection_unit #(
        .REG_W (REG_W)
    ) u_hdu (
        .idex_memread_i  (ctrl_q.memread),
        .idex_reg_rt_i   (rt_q),
        .ifid_reg_rs_i   (IFID_reg_rs),
        .ifid_reg_rt_i   (IFID_reg_rt),
        .flush_i         (flush),
        .load_use_o      (load_use_w),
        .pc_write_o      (pc_write_w),
        .ifid_write_o    (ifid_write_w),
        .insert_bubble_o (insert_bubble_w)
    );

    // Select what enters EX next: the ID instruction, or an all-zero bubble
    // whose zeroed register numbers cannot match in the forwarding unit.
    always_comb begin
        rs_d    = IFID_reg_rs;
        rt_d    = IFID_reg_rt;
        rd_d    = IFID_reg_rd;
        data1_d = reg_read_data_1;
        data2_d = reg_read_data_2;
        imm_d   = sign_ext_imm;
        ctrl_d  = id_ctrl;
        if (insert_bubble_w) begin
            rs_d    = '0;
            rt_d    = '0;
            rd_d    = '0;
            data1_d = '0;
            data2_d = '0;
            imm_d   = '0;
            ctrl_d  = CTRL_BUBBLE;
        end
    end

    // Count only real stalls (not flushes); hold at all-ones instead of wrapping.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (load_use_w && !flush && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // Register update; reset takes priority over any pending stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            rs_q        <= '0;
            rt_q        <= '0;
            rd_q        <= '0;
            data1_q     <= '0;
            data2_q     <= '0;
            imm_q       <= '0;
            ctrl_q      <= CTRL_BUBBLE;
            stall_cnt_q <= '0;
        end else begin
            rs_q        <= rs_d;
            rt_q        <= rt_d;
            rd_q        <= rd_d;
            data1_q     <= data1_d;
            data2_q     <= data2_d;
            imm_q       <= imm_d;
            ctrl_q      <= ctrl_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign IDEX_reg_rs      = rs_q;
    assign IDEX_reg_rt      = rt_q;
    assign IDEX_reg_rd      = rd_q;
    assign IDEX_read_data_1 = data1_q;
    assign IDEX_read_data_2 = data2_q;
    assign IDEX_imm         = imm_q;
    assign IDEX_ctrl        = ctrl_q;
    assign pc_write         = pc_write_w;
    assign IFID_write       = ifid_write_w;
    assign stall_count      = stall_cnt_q;

endmodule

// File: tb/tb_idex_stage.sv
// Bench for idex_stage: directed instruction sequences, a behavioural model
// of the ID/EX boundary checked every cycle, and literal spot checks.
// A second instance with a 2-bit counter exercises counter saturation.
module tb_idex_stage;
    import cpu_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic [4:0]  IFID_reg_rs = '0, IFID_reg_rt = '0, IFID_reg_rd = '0;
    logic [31:0] reg_read_data_1 = '0, reg_read_data_2 = '0, sign_ext_imm = '0;
    ctrl_t       id_ctrl = '0;
    logic        flush = 1'b0;

    logic [4:0]  IDEX_reg_rs, IDEX_reg_rt, IDEX_reg_rd;
    logic [31:0] IDEX_read_data_1, IDEX_read_data_2, IDEX_imm;
    ctrl_t       IDEX_ctrl;
    logic        pc_write, IFID_write;
    logic [31:0] stall_count;

    logic [4:0]  s_rs, s_rt, s_rd;
    logic [31:0] s_d1, s_d2, s_imm;
    ctrl_t       s_ctrl;
    logic        s_pc_write, s_ifid_write;
    logic [1:0]  s_stall_count;

    idex_stage #(.DATA_W(32), .REG_W(5), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .IFID_reg_rs(IFID_reg_rs), .IFID_reg_rt(IFID_reg_rt), .IFID_reg_rd(IFID_reg_rd),
        .reg_read_data_1(reg_read_data_1), .reg_read_data_2(reg_read_data_2),
        .sign_ext_imm(sign_ext_imm), .id_ctrl(id_ctrl), .flush(flush),
        .IDEX_reg_rs(IDEX_reg_rs), .IDEX_reg_rt(IDEX_reg_rt), .IDEX_reg_rd(IDEX_reg_rd),
        .IDEX_read_data_1(IDEX_read_data_1), .IDEX_read_data_2(IDEX_read_data_2),
        .IDEX_imm(IDEX_imm), .IDEX_ctrl(IDEX_ctrl),
        .pc_write(pc_write), .IFID_write(IFID_write), .stall_count(stall_count)
    );

    idex_stage #(.DATA_W(32), .REG_W(5), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst),
        .IFID_reg_rs(IFID_reg_rs), .IFID_reg_rt(IFID_reg_rt), .IFID_reg_rd(IFID_reg_rd),
        .reg_read_data_1(reg_read_data_1), .reg_read_data_2(reg_read_data_2),
        .sign_ext_imm(sign_ext_imm), .id_ctrl(id_ctrl), .flush(flush),
        .IDEX_reg_rs(s_rs), .IDEX_reg_rt(s_rt), .IDEX_reg_rd(s_rd),
        .IDEX_read_data_1(s_d1), .IDEX_read_data_2(s_d2),
        .IDEX_imm(s_imm), .IDEX_ctrl(s_ctrl),
        .pc_write(s_pc_write), .IFID_write(s_ifid_write), .stall_count(s_stall_count)
    );

    // ---------------- scoreboard bookkeeping ----------------
    int tests_run = 0;
    int tests_failed = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The model tracks "the instruction now in EX" as a record, plus stall
    // totals for both counter widths. Updated on each rising edge from the
    // inputs presented during the preceding cycle.
    typedef struct {
        logic [4:0]  rs, rt, rd;
        logic [31:0] d1, d2, imm;
        ctrl_t       ctrl;
    } instr_t;

    instr_t      m_ex;
    instr_t      nop_instr;
    longint      m_stalls;      // unbounded stall total since reset
    bit          m_started = 0;

    function automatic bit model_load_use();
        // A load in EX blocks an ID instruction that reads its destination,
        // unless that destination is $zero.
        return m_ex.ctrl.memread && (m_ex.rt != 0) &&
               (m_ex.rt == IFID_reg_rs || m_ex.rt == IFID_reg_rt);
    endfunction

    initial begin
        nop_instr = '{rs: 0, rt: 0, rd: 0, d1: 0, d2: 0, imm: 0, ctrl: '0};
        m_ex = nop_instr;
        m_stalls = 0;
    end

    always @(posedge clk) begin
        if (rst) begin
            m_ex = nop_instr;
            m_stalls = 0;
            m_started = 1;
        end else begin
            if (model_load_use() && !flush) m_stalls = m_stalls + 1;
            if (flush || model_load_use())
                m_ex = nop_instr;
            else
                m_ex = '{rs: IFID_reg_rs, rt: IFID_reg_rt, rd: IFID_reg_rd,
                         d1: reg_read_data_1, d2: reg_read_data_2,
                         imm: sign_ext_imm, ctrl: id_ctrl};
        end
    end

    // Compare process: mid-cycle, all outputs against the model.
    always @(negedge clk) begin
        if (m_started) begin
            logic        exp_front;
            logic [31:0] exp_cnt;
            logic [1:0]  exp_cnt_s;
            exp_front = !(model_load_use() && !flush);
            exp_cnt   = (m_stalls > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(m_stalls);
            exp_cnt_s = (m_stalls > 3) ? 2'd3 : 2'(m_stalls);
            chk("mdl_rs",    64'(IDEX_reg_rs),      64'(m_ex.rs));
            chk("mdl_rt",    64'(IDEX_reg_rt),      64'(m_ex.rt));
            chk("mdl_rd",    64'(IDEX_reg_rd),      64'(m_ex.rd));
            chk("mdl_d1",    64'(IDEX_read_data_1), 64'(m_ex.d1));
            chk("mdl_d2",    64'(IDEX_read_data_2), 64'(m_ex.d2));
            chk("mdl_imm",   64'(IDEX_imm),         64'(m_ex.imm));
            chk("mdl_ctrl",  64'(IDEX_ctrl),        64'(m_ex.ctrl));
            chk("mdl_pcw",   64'(pc_write),         64'(exp_front));
            chk("mdl_ifidw", 64'(IFID_write),       64'(exp_front));
            chk("mdl_cnt",   64'(stall_count),      64'(exp_cnt));
            chk("mdl_cnt_s", 64'(s_stall_count),    64'(exp_cnt_s));
            chk("mdl_ctrl_s",64'(s_ctrl),           64'(m_ex.ctrl));
        end
    end

    // ---------------- driver tasks ----------------
    // Inputs change 2 time units after the rising edge.
    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                         input ctrl_t c, input logic fl);
        IFID_reg_rs = rs; IFID_reg_rt = rt; IFID_reg_rd = rd;
        reg_read_data_1 = d1; reg_read_data_2 = d2; sign_ext_imm = imm;
        id_ctrl = c; flush = fl;
    endtask

    function automatic ctrl_t mk_ctrl(input bit rw, input bit mr, input bit mw, input bit m2r,
                                      input bit asrc, input bit rdst, input logic [1:0] op);
        ctrl_t c;
        c.regwrite = rw; c.memread = mr; c.memwrite = mw; c.memtoreg = m2r;
        c.alusrc = asrc; c.regdst = rdst; c.aluop = op;
        return c;
    endfunction

    ctrl_t c_lw, c_add, c_rw_only;

    // Watchdog: the sequence is fixed-length; this only guards against a hang.
    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        tests_failed++;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        c_lw      = mk_ctrl(1, 1, 0, 1, 1, 0, ALUOP_ADD);
        c_add     = mk_ctrl(1, 0, 0, 0, 0, 1, ALUOP_RTYPE);
        c_rw_only = mk_ctrl(1, 0, 0, 0, 0, 0, ALUOP_ADD);

        // Reset for two cycles.
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, '0, 0);
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk("rst_ctrl",  64'(IDEX_ctrl), 64'h0);
        chk("rst_rs",    64'(IDEX_reg_rs), 64'h0);
        chk("rst_d1",    64'(IDEX_read_data_1), 64'h0);
        chk("rst_imm",   64'(IDEX_imm), 64'h0);
        chk("rst_cnt",   64'(stall_count), 64'h0);
        chk("rst_pcw",   64'(pc_write), 64'h1);
        chk("rst_ifidw", 64'(IFID_write), 64'h1);
        rst = 1'b0;

        // Pass-through: values appear in EX one cycle later.
        drive(3, 4, 5, 32'h11, 32'h22, 32'hFFFF_FFF0, c_rw_only, 0);
        @(negedge clk);
        chk("pt_pcw_pre", 64'(pc_write), 64'h1);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, '0, 0);
        @(negedge clk);
        chk("pt_rs",   64'(IDEX_reg_rs), 64'd3);
        chk("pt_rt",   64'(IDEX_reg_rt), 64'd4);
        chk("pt_rd",   64'(IDEX_reg_rd), 64'd5);
        chk("pt_d1",   64'(IDEX_read_data_1), 64'h11);
        chk("pt_d2",   64'(IDEX_read_data_2), 64'h22);
        chk("pt_imm",  64'(IDEX_imm), 64'hFFFF_FFF0);
        chk("pt_ctrl", 64'(IDEX_ctrl), 64'h80);
        chk("pt_cnt",  64'(stall_count), 64'h0);

        // Load-use: lw $8 in EX, add reading $8 in ID.
        drive(1, 8, 0, 32'h100, 32'h0, 32'h4, c_lw, 0);
        next_cycle();
        drive(8, 9, 10, 32'hAAAA, 32'hBBBB, 32'h0, c_add, 0);
        @(negedge clk);
        chk("lu_pcw",   64'(pc_write), 64'h0);
        chk("lu_ifidw", 64'(IFID_write), 64'h0);
        next_cycle();
        @(negedge clk);
        chk("lu_bubble_ctrl", 64'(IDEX_ctrl), 64'h0);
        chk("lu_bubble_rt",   64'(IDEX_reg_rt), 64'h0);
        chk("lu_cnt",         64'(stall_count), 64'd1);
        chk("lu_pcw_after",   64'(pc_write), 64'h1);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, '0, 0);
        @(negedge clk);
        chk("lu_add_rs",   64'(IDEX_reg_rs), 64'd8);
        chk("lu_add_d1",   64'(IDEX_read_data_1), 64'hAAAA);
        chk("lu_add_ctrl", 64'(IDEX_ctrl), 64'(c_add));

        // Load targeting $0 never stalls.
        drive(0, 0, 0, 0, 0, 0, c_lw, 0);
        next_cycle();
        drive(0, 0, 11, 32'h5, 32'h6, 32'h0, c_add, 0);
        @(negedge clk);
        chk("z_pcw", 64'(pc_write), 64'h1);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, '0, 0);
        @(negedge clk);
        chk("z_cnt",  64'(stall_count), 64'd1);
        chk("z_rd",   64'(IDEX_reg_rd), 64'd11);

        // Flush and load-use together: flush wins, no stall counted.
        drive(2, 7, 0, 0, 0, 32'h8, c_lw, 0);
        next_cycle();
        drive(7, 3, 12, 32'h77, 32'h33, 0, c_add, 1);
        @(negedge clk);
        chk("fl_pcw",   64'(pc_write), 64'h1);
        chk("fl_ifidw", 64'(IFID_write), 64'h1);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, '0, 0);
        @(negedge clk);
        chk("fl_ctrl", 64'(IDEX_ctrl), 64'h0);
        chk("fl_rs",   64'(IDEX_reg_rs), 64'h0);
        chk("fl_d1",   64'(IDEX_read_data_1), 64'h0);
        chk("fl_cnt",  64'(stall_count), 64'd1);

        // Five more stalls: 32-bit counter reaches 6, the 2-bit one holds at 3.
        for (int i = 0; i < 5; i++) begin
            drive(1, 6, 0, 0, 0, 0, c_lw, 0);
            next_cycle();
            drive(5'(i), 6, 13, 32'(i), 0, 0, c_add, 0);
            next_cycle();   // stall cycle
            next_cycle();   // consumer captured
            drive(0, 0, 0, 0, 0, 0, '0, 0);
        end
        @(negedge clk);
        chk("sat_cnt32", 64'(stall_count), 64'd6);
        chk("sat_cnt2",  64'(s_stall_count), 64'd3);

        // Reset asserted during a stall cycle clears everything, no increment.
        drive(1, 6, 0, 0, 0, 0, c_lw, 0);
        next_cycle();
        drive(6, 2, 14, 32'h9, 0, 0, c_add, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("rs_pcw_stall", 64'(pc_write), 64'h0);
        next_cycle();
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, '0, 0);
        @(negedge clk);
        chk("rs_cnt",   64'(stall_count), 64'h0);
        chk("rs_cnt2",  64'(s_stall_count), 64'h0);
        chk("rs_ctrl",  64'(IDEX_ctrl), 64'h0);
        chk("rs_rs",    64'(IDEX_reg_rs), 64'h0);
        chk("rs_pcw",   64'(pc_write), 64'h1);
        chk("rs_ifidw", 64'(IFID_write), 64'h1);

        next_cycle();
        next_cycle();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
